// File: rtl/proj_security_pkg.sv
// Shared constants and sensor-word decoding for the building security controller.
package proj_security_pkg;

  localparam int SENSOR_W = 3;
  localparam int DET_BIT  = 2;
  localparam int ID_MSB   = 1;
  localparam int CODE_W   = 12;
  localparam logic [CODE_W-1:0] VALID_CODE_DEF = 12'd731;

  // A sensor word counts only when its embedded id matches the sector it is wired to.
  function automatic logic sensor_hit(input logic [SENSOR_W-1:0] word,
                                      input logic [ID_MSB:0]     id);
    return word[DET_BIT] && (word[ID_MSB:0] == id);
  endfunction

endpackage

// File: rtl/proj_security_if.sv
// Sensor inputs and actuator outputs of the security controller.
interface proj_security_if;
  import proj_security_pkg::*;

  logic                fire;
  logic                earth_quake;
  logic [SENSOR_W-1:0] mds0, mds1, mds2, mds3;
  logic [SENSOR_W-1:0] cam0, cam1, cam2, cam3;
  logic [CODE_W-1:0]   access_code;
  logic                sec0, sec1, sec2, sec3;
  logic                door;
  logic                fire_exit;
  logic                fire_dept_alert;
  logic                fire_alarm;
  logic                server_backup_signal;

  modport master (
    output fire, earth_quake, mds0, mds1, mds2, mds3, cam0, cam1, cam2, cam3, access_code,
    input  sec0, sec1, sec2, sec3, door, fire_exit, fire_dept_alert, fire_alarm,
           server_backup_signal
  );

  modport slave (
    input  fire, earth_quake, mds0, mds1, mds2, mds3, cam0, cam1, cam2, cam3, access_code,
    output sec0, sec1, sec2, sec3, door, fire_exit, fire_dept_alert, fire_alarm,
           server_backup_signal
  );
endinterface

// File: rtl/proj_security_sector_monitor.sv
// Combinational intrusion flag for one sector from its MDS and camera words.
module sector_monitor
  import proj_security_pkg::*;
#(
  parameter logic [ID_MSB:0] SECTOR_ID = '0
) (
  input  logic [SENSOR_W-1:0] mds,
  input  logic [SENSOR_W-1:0] cam,
  output logic                sec
);

  always_comb begin
    sec = sensor_hit(mds, SECTOR_ID) | sensor_hit(cam, SECTOR_ID);
  end

endmodule

// File: rtl/proj_security.sv
// Security/safety controller: sector intrusion flags, emergency response and door control,
// all driven from a single registered output bank.
module proj_security
  import proj_security_pkg::*;
#(
  parameter logic [CODE_W-1:0] VALID_CODE = VALID_CODE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  proj_security_if.slave bus
);

  logic [3:0] sec_nxt;
  logic       emergency;
  logic       intrusion;
  logic       door_nxt;

  sector_monitor #(.SECTOR_ID(2'd0)) u_sec0 (.mds(bus.mds0), .cam(bus.cam0), .sec(sec_nxt[0]));
  sector_monitor #(.SECTOR_ID(2'd1)) u_sec1 (.mds(bus.mds1), .cam(bus.cam1), .sec(sec_nxt[1]));
  sector_monitor #(.SECTOR_ID(2'd2)) u_sec2 (.mds(bus.mds2), .cam(bus.cam2), .sec(sec_nxt[2]));
  sector_monitor #(.SECTOR_ID(2'd3)) u_sec3 (.mds(bus.mds3), .cam(bus.cam3), .sec(sec_nxt[3]));

  // Intrusion uses this cycle's sector values, so a correct code is refused in the same cycle.
  always_comb begin
    emergency = bus.fire | bus.earth_quake;
    intrusion = |sec_nxt;
    door_nxt  = emergency | ((bus.access_code == VALID_CODE) & ~intrusion);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sec0                 <= '0;
      bus.sec1                 <= '0;
      bus.sec2                 <= '0;
      bus.sec3                 <= '0;
      bus.door                 <= '0;
      bus.fire_exit            <= '0;
      bus.fire_dept_alert      <= '0;
      bus.fire_alarm           <= '0;
      bus.server_backup_signal <= '0;
    end else begin
      bus.sec0                 <= sec_nxt[0];
      bus.sec1                 <= sec_nxt[1];
      bus.sec2                 <= sec_nxt[2];
      bus.sec3                 <= sec_nxt[3];
      bus.door                 <= door_nxt;
      bus.fire_exit            <= emergency;
      bus.fire_dept_alert      <= bus.fire;
      bus.fire_alarm           <= emergency;
      bus.server_backup_signal <= emergency;
    end
  end

endmodule

// File: tb/tb_proj_security.sv
// Scoreboard bench for proj_security: directed scenarios followed by randomized traffic.
module tb_proj_security;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proj_security_if bus();

  proj_security #(.VALID_CODE(12'd731)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic             fire, quake;
  logic [3:0][2:0]  mds, cam;
  logic [11:0]      code;

  assign bus.fire        = fire;
  assign bus.earth_quake = quake;
  assign bus.mds0 = mds[0];
  assign bus.mds1 = mds[1];
  assign bus.mds2 = mds[2];
  assign bus.mds3 = mds[3];
  assign bus.cam0 = cam[0];
  assign bus.cam1 = cam[1];
  assign bus.cam2 = cam[2];
  assign bus.cam3 = cam[3];
  assign bus.access_code = code;

  logic [8:0] exp_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         stim_done = 0;

  // Expected vector: {sec3,sec2,sec1,sec0,door,fire_exit,fire_dept_alert,fire_alarm,server_backup}
  function automatic logic [8:0] model(input logic r, input logic f, input logic q,
                                       input logic [3:0][2:0] m, input logic [3:0][2:0] c,
                                       input logic [11:0] k);
    logic [3:0] s;
    logic       em, dr;
    s = '0;
    for (int n = 0; n < 4; n++) begin
      if ((int'(m[n]) / 4 == 1) && (int'(m[n]) % 4 == n)) s[n] = 1'b1;
      if ((int'(c[n]) / 4 == 1) && (int'(c[n]) % 4 == n)) s[n] = 1'b1;
    end
    em = f || q;
    dr = em || (k == 12'd731 && s == 4'd0);
    if (r) return '0;
    return {s, dr, em, f, em, em};
  endfunction

  task automatic apply(input logic r, input logic f, input logic q,
                       input logic [3:0][2:0] m, input logic [3:0][2:0] c,
                       input logic [11:0] k);
    @(negedge clk);
    rst = r; fire = f; quake = q; mds = m; cam = c; code = k;
    exp_q.push_back(model(r, f, q, m, c, k));
  endtask

  // Idle words: every sensor reports its own id with no detection.
  function automatic logic [3:0][2:0] idle_words();
    logic [3:0][2:0] w;
    for (int n = 0; n < 4; n++) w[n] = 3'(n);
    return w;
  endfunction

  initial begin : monitor
    logic [8:0] act, exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {bus.sec3, bus.sec2, bus.sec1, bus.sec0, bus.door, bus.fire_exit,
               bus.fire_dept_alert, bus.fire_alarm, bus.server_backup_signal};
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL outputs t=%0t got=%b expected=%b", $time, act, exp_v);
      end
    end
  end

  initial begin : stim
    logic [3:0][2:0] m, c, idl;
    idl = idle_words();
    rst = 1'b1; fire = 1'b0; quake = 1'b0; mds = idl; cam = idl; code = 12'd123;

    apply(1, 0, 0, idl, idl, 12'd123);   // reset state
    apply(0, 0, 0, idl, idl, 12'd123);   // idle
    apply(0, 1, 0, idl, idl, 12'd294);   // fire only
    apply(0, 0, 1, idl, idl, 12'd294);   // quake only
    apply(0, 1, 1, idl, idl, 12'd294);   // both
    c = idl; c[1] = 3'b101;
    apply(0, 0, 0, idl, c, 12'd123);
    m = idl; m[3] = 3'b111;
    apply(0, 0, 0, m, idl, 12'd123);
    c = idl; c[2] = 3'b100;              // wrong id, ignored
    apply(0, 0, 0, idl, c, 12'd123);
    apply(0, 0, 0, idl, idl, 12'd731);   // access granted
    m = idl; m[2] = 3'b110;
    apply(0, 0, 0, m, idl, 12'd731);     // access refused by intrusion
    m = idl; m[0] = 3'b100; m[3] = 3'b111; c = idl; c[2] = 3'b110;
    apply(0, 1, 0, m, c, 12'd731);       // mixed
    apply(0, 1, 0, idl, idl, 12'd294);
    apply(1, 1, 0, idl, idl, 12'd294);   // reset mid-run
    apply(0, 1, 0, idl, idl, 12'd294);   // resume

    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 4; n++) begin
        m[n][2]   = 1'($urandom_range(0, 1));
        m[n][1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(n);
        c[n][2]   = 1'($urandom_range(0, 1) & $urandom_range(0, 1));
        c[n][1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(n);
      end
      apply(($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), m, c,
            ($urandom_range(0, 1) == 0) ? 12'd731 : 12'($urandom));
    end

    repeat (3) @(negedge clk);
    stim_done = 1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout stim_done=%0d expected=1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
